alu_serial_ctrl: RTL and testbench

Bit-serial WIDTH-bit ALU sequencer that time-multiplexes one instance of the existing 1-bit ALU slice over WIDTH cycles, LSB first.
- Latches operands and a 4-bit ALU control code on a start handshake.
- Drives the slice's invert, carry and operation inputs each cycle.
- Assembles the result and the zero/cout/overflow flags.
- Serves as the area-minimal ALU option beside the ripple-array ALU.

---
 rtl/alu_serial_ctrl_pkg.sv | 49 ++++
 rtl/alu_serial_ctrl_slice.sv | 31 +++
 rtl/alu_serial_ctrl.sv | 116 +++++++++++
 tb/tb_alu_serial_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: ALU control codes,
// slice operation encodings, FSM states and the per-code slice drive decode.
package alu_serial_ctrl_pkg;

   localparam logic [3:0] CTRL_AND = 4'b0000;
   localparam logic [3:0] CTRL_OR  = 4'b0001;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] CTRL_SUB = 4'b0110;
   localparam logic [3:0] CTRL_SLT = 4'b0111;
   localparam logic [3:0] CTRL_NOR = 4'b1100;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_LESS = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   typedef struct packed {
      logic       legal;
      logic       a_inv;
      logic       b_inv;
      logic [1:0] op;
      logic       arith;
      logic       slt;
   } drive_t;

   function automatic drive_t decode(input logic [3:0] c);
      drive_t d;
      d = '0;
      d.legal = 1'b1;
      case (c)
         CTRL_AND: d.op = OP_AND;
         CTRL_OR:  d.op = OP_OR;
         CTRL_ADD: begin d.op = OP_ADD; d.arith = 1'b1; end
         CTRL_SUB: begin d.op = OP_ADD; d.b_inv = 1'b1; d.arith = 1'b1; end
         CTRL_SLT: begin d.op = OP_ADD; d.b_inv = 1'b1; d.slt = 1'b1; end
         CTRL_NOR: begin d.op = OP_AND; d.a_inv = 1'b1; d.b_inv = 1'b1; end
         default:  d.legal = 1'b0;
      endcase
      return d;
   endfunction

   // Subtraction (and SLT) seed the carry chain with the +1 of two's complement.
   function automatic logic init_cin(input logic [3:0] c);
      return (c == CTRL_SUB) || (c == CTRL_SLT);
   endfunction

endpackage

// File: rtl/alu_serial_ctrl_slice.sv
// One-bit ALU slice: optional operand inversion, AND/OR/full-add/less select.
module alu_serial_ctrl_slice
   import alu_serial_ctrl_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       a_inv,
   input  logic       b_inv,
   input  logic       cin,
   input  logic       less,
   input  logic [1:0] op,
   output logic       res,
   output logic       cout
);

   logic aa, bb;

   always_comb begin
      aa   = a ^ a_inv;
      bb   = b ^ b_inv;
      cout = (aa & bb) | (aa & cin) | (bb & cin);
      case (op)
         OP_AND:  res = aa & bb;
         OP_OR:   res = aa | bb;
         OP_ADD:  res = aa ^ bb ^ cin;
         OP_LESS: res = less;
         default: res = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: feeds one 1-bit slice LSB first over WIDTH cycles,
// then registers the assembled result and flags for a single done cycle.
module alu_serial_ctrl
   import alu_serial_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [3:0]       ctrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             ready_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             cout_o,
   output logic             overflow_o
);

   state_t           state, nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [WIDTH-2:0] res_sh;
   logic             carry;
   drive_t           drv_q;

   logic             s_res, s_cout;
   logic             last, ovf;
   logic [WIDTH-1:0] full_res, fin_res;

   alu_serial_ctrl_slice u_slice (
      .a     (a_sh[0]),
      .b     (b_sh[0]),
      .a_inv (drv_q.a_inv),
      .b_inv (drv_q.b_inv),
      .cin   (carry),
      .less  (1'b0),
      .op    (drv_q.op),
      .res   (s_res),
      .cout  (s_cout)
   );

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  if (start_i) nxt = S_RUN;
         S_RUN:   if (last) nxt = S_DONE;
         S_DONE:  nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ready_o = (state == S_IDLE);
      done_o  = (state == S_DONE);
   end

   // The final slice bit joins the shift reg combinationally so the full
   // result lands in result_o on the same edge that processes the MSB.
   always_comb begin
      last     = (cnt == CNT_W'(WIDTH - 1));
      full_res = {s_res, res_sh};
      ovf      = carry ^ s_cout;
      if (!drv_q.legal)  fin_res = '0;
      else if (drv_q.slt) fin_res = {{(WIDTH-1){1'b0}}, s_res ^ ovf};
      else               fin_res = full_res;
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         a_sh       <= '0;
         b_sh       <= '0;
         res_sh     <= '0;
         carry      <= 1'b0;
         drv_q      <= '0;
         result_o   <= '0;
         zero_o     <= 1'b0;
         cout_o     <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start_i) begin
               a_sh  <= src1_i;
               b_sh  <= src2_i;
               drv_q <= decode(ctrl_i);
               carry <= init_cin(ctrl_i);
               cnt   <= '0;
            end
            S_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= full_res[WIDTH-1:1];
               carry  <= s_cout;
               cnt    <= cnt + CNT_W'(1);
               if (last) begin
                  result_o   <= fin_res;
                  zero_o     <= (fin_res == '0);
                  cout_o     <= drv_q.arith & s_cout;
                  overflow_o <= drv_q.arith & ovf;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl: accepted requests push model results,
// a monitor pops and compares on every done pulse.
module tb_alu_serial_ctrl;
   localparam int W = 32;

   logic          clk_i = 1'b0, rst_n = 1'b0, start_i = 1'b0;
   logic [3:0]    ctrl_i = '0;
   logic [W-1:0]  src1_i = '0, src2_i = '0;
   logic          ready_o, done_o, zero_o, cout_o, overflow_o;
   logic [W-1:0]  result_o;

   typedef struct packed {
      logic [W-1:0] r;
      logic         z, c, v;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0, errors = 0;
   logic done_d = 1'b0;

   alu_serial_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
      .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .ctrl_i(ctrl_i),
      .src1_i(src1_i), .src2_i(src2_i), .ready_o(ready_o), .done_o(done_o),
      .result_o(result_o), .zero_o(zero_o), .cout_o(cout_o), .overflow_o(overflow_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      logic [W:0] s;
      e = '0;
      case (c)
         4'b0000: e.r = a & b;
         4'b0001: e.r = a | b;
         4'b1100: e.r = ~(a | b);
         4'b0010: begin
            s = {1'b0, a} + {1'b0, b};
            e.r = s[W-1:0]; e.c = s[W];
            e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
         end
         4'b0110: begin
            s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            e.r = s[W-1:0]; e.c = s[W];
            e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
         end
         4'b0111: e.r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         default: e.r = '0;
      endcase
      e.z = (e.r == '0);
      return e;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk_i)
      if (rst_n && start_i && ready_o) sbq.push_back(model(ctrl_i, src1_i, src2_i));

   always @(negedge rst_n) sbq.delete();

   always @(negedge clk_i) begin
      exp_t e;
      if (done_o) begin
         check("done_pulse", W'(done_d), W'(0));
         if (sbq.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_done: got done_o=1 expected no pending op (t=%0t)", $time);
         end else begin
            e = sbq.pop_front();
            check("result", result_o, e.r);
            check("zero", W'(zero_o), W'(e.z));
            check("cout", W'(cout_o), W'(e.c));
            check("overflow", W'(overflow_o), W'(e.v));
         end
      end
      done_d = done_o;
   end

   // Called at a negedge; returns at the negedge after ready_o returns high.
   task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      int k;
      k = 0;
      while (!ready_o && k < 100) begin @(negedge clk_i); k++; end
      check("ready_wait", W'(ready_o), W'(1));
      ctrl_i = c; src1_i = a; src2_i = b; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      src1_i = $urandom(); src2_i = $urandom(); ctrl_i = 4'($urandom());
      @(negedge clk_i);
      check("ready_busy", W'(ready_o), W'(0));
      k = 0;
      while (!done_o && k < W + 10) begin @(posedge clk_i); k++; @(negedge clk_i); end
      check("latency", W'(k), W'(W));
      @(negedge clk_i);
      check("ready_after", W'(ready_o), W'(1));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within time budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] codes [6];
      int k;
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

      #12;
      check("rst_result", result_o, '0);
      check("rst_flags", W'({zero_o, cout_o, overflow_o, done_o}), W'(0));
      @(negedge clk_i); rst_n = 1'b1;
      check("rst_ready", W'(ready_o), W'(1));
      @(negedge clk_i);

      run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
      check("add_ovf_const", result_o, 32'h8000_0000);
      check("add_ovf_flag", W'(overflow_o), W'(1));
      run_op(4'b0110, 32'h5, 32'h5);
      check("sub_zero_const", W'({zero_o, cout_o, overflow_o}), W'(3'b110));
      run_op(4'b0111, 32'h8000_0000, 32'h1);
      check("slt_neg_const", result_o, 32'h1);
      run_op(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000);
      check("slt_ovf_const", result_o, 32'h0);
      run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
      check("and_const", result_o, 32'hF000_F000);
      run_op(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00);
      check("or_const", result_o, 32'hFFF0_FFF0);
      run_op(4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00);
      check("nor_const", result_o, 32'h000F_000F);
      run_op(4'b1111, 32'h1234_5678, 32'h1);
      check("illegal_const", W'({zero_o, result_o == 0}), W'(2'b11));

      // start held high across an op with operands changing mid-run
      ctrl_i = 4'b0010; src1_i = 32'd100; src2_i = 32'd23; start_i = 1'b1;
      @(posedge clk_i);
      repeat (5) @(negedge clk_i);
      src1_i = 32'd1000; src2_i = 32'd2000;
      k = 0;
      while (!done_o && k < W + 10) begin @(negedge clk_i); k++; end
      check("held_first", result_o, 32'd123);
      @(posedge clk_i); @(posedge clk_i); #1;
      start_i = 1'b0;
      k = 0;
      @(negedge clk_i);
      while (!done_o && k < W + 10) begin @(negedge clk_i); k++; end
      check("held_second", result_o, 32'd3000);
      @(negedge clk_i);

      // reset in the middle of an ADD
      ctrl_i = 4'b0010; src1_i = 32'd5; src2_i = 32'd6; start_i = 1'b1;
      @(posedge clk_i); #1 start_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #2 rst_n = 1'b0;
      #1;
      check("abort_result", result_o, '0);
      check("abort_flags", W'({zero_o, cout_o, overflow_o, done_o}), W'(0));
      @(negedge clk_i); rst_n = 1'b1;
      check("abort_ready", W'(ready_o), W'(1));
      @(negedge clk_i);
      run_op(4'b0010, 32'd3, 32'd4);
      check("post_abort_add", result_o, 32'd7);

      repeat (40) begin
         logic [3:0] c;
         c = codes[$urandom_range(0, 5)];
         if ($urandom_range(0, 7) == 0) c = ($urandom_range(0, 1) == 0) ? 4'b0011 : 4'b1111;
         run_op(c, $urandom(), ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : $urandom());
      end

      repeat (3) @(negedge clk_i);
      check("queue_empty", W'(sbq.size()), W'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
